// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SLICE_W = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder8.sv
// Shared 8-bit adder: carry_in both inverts b and injects the bit-0 carry.
module adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] sum,
   output logic       carry_out
);

   logic [8:0] total;

   assign total     = {1'b0, a} + {1'b0, b ^ {8{carry_in}}} + 9'(carry_in);
   assign sum       = total[7:0];
   assign carry_out = total[8];

endmodule

// File: rtl/multiword_addsub_seq.sv
// Multi-precision add/subtract that walks WORDS byte slices LSB first through one adder8,
// chaining carry/borrow through a register.
module multiword_addsub_seq
   import adder_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sub,
   input  logic [WORDS*SLICE_W-1:0]   a,
   input  logic [WORDS*SLICE_W-1:0]   b,
   output logic                       busy,
   output logic                       done,
   output logic [WORDS*SLICE_W-1:0]   y,
   output logic                       carry_out,
   output logic                       overflow
);

   localparam int unsigned N     = WORDS * SLICE_W;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t             state;
   state_t             state_next;
   logic               accept_c;
   logic               last_c;

   logic [N-1:0]       a_q;
   logic [N-1:0]       b_q;
   logic               sub_q;
   logic               c;
   logic [IDX_W-1:0]   idx;

   logic [SLICE_W-1:0] ak_c;
   logic [SLICE_W-1:0] bk_c;
   logic [SLICE_W-1:0] beff_c;
   logic [SLICE_W-1:0] badj_c;
   logic [SLICE_W-1:0] sum_c;
   logic               cout_c;

   assign last_c = (idx == IDX_W'(WORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and accept decode; start is only honoured outside RUN
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_c) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Slice select and pre-inversion: adder8 re-inverts by c, leaving b^sub plus carry c
   always_comb begin
      ak_c   = a_q[idx*SLICE_W +: SLICE_W];
      bk_c   = b_q[idx*SLICE_W +: SLICE_W];
      beff_c = bk_c ^ {SLICE_W{sub_q}};
      badj_c = bk_c ^ {SLICE_W{sub_q ^ c}};
   end

   adder8 u_adder8 (
      .a         (ak_c),
      .b         (badj_c),
      .carry_in  (c),
      .sum       (sum_c),
      .carry_out (cout_c)
   );

   // Operand latch, slice walk and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         c         <= 1'b0;
         idx       <= '0;
         y         <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= (state_next == RUN);
         done <= (state_next == DONE);
         if (accept_c) begin
            a_q       <= a;
            b_q       <= b;
            sub_q     <= sub;
            c         <= sub;
            idx       <= '0;
            y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
         end else if (state == RUN) begin
            y[idx*SLICE_W +: SLICE_W] <= sum_c;
            c   <= cout_c;
            idx <= idx + IDX_W'(1);
            if (last_c) begin
               carry_out <= cout_c;
               overflow  <= (ak_c[SLICE_W-1] == beff_c[SLICE_W-1]) &&
                            (sum_c[SLICE_W-1] != ak_c[SLICE_W-1]);
            end
         end
      end
   end

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Self-checking bench for multiword_addsub_seq (WORDS=4) against a wide-arithmetic model.
module tb_multiword_addsub_seq;

   localparam int unsigned WORDS = 4;
   localparam int unsigned N     = 8 * WORDS;
   localparam int          LIMIT = 50;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] y;
   logic         carry_out;
   logic         overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   multiword_addsub_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .y         (y),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference: full-width unsigned/signed arithmetic
   function automatic void ref_op(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rs,
                                  output logic [N-1:0] ry, output logic rco, output logic rov);
      logic [N:0] wide;
      if (!rs) begin
         wide = {1'b0, ra} + {1'b0, rb};
         ry   = wide[N-1:0];
         rco  = wide[N];
         rov  = (ra[N-1] == rb[N-1]) && (ry[N-1] != ra[N-1]);
      end else begin
         ry   = ra - rb;
         rco  = (ra >= rb);
         rov  = (ra[N-1] != rb[N-1]) && (ry[N-1] != ra[N-1]);
      end
   endfunction

   // Present operands at the current negedge, let the next edge accept, drop start
   task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is);
      a     = ia;
      b     = ib;
      sub   = is;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for done; edges counts edges since (and including) the accepting edge
   task automatic wait_done(input int e0, output int edges, output logic timed_out);
      edges     = e0;
      timed_out = 1'b0;
      while (!done) begin
         if (edges >= LIMIT) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, y, carry_out, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b y=%h co=%b ov=%b, required all zero",
                  busy, done, y, carry_out, overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [N-1:0] ta [6];
      logic [N-1:0] tb_ [6];
      logic         ts [6];
      logic [N-1:0] ey [6];
      logic         eco [6];
      logic         eov [6];
      int           edges;
      logic         to;
      ta = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h12345678};
      tb_ = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h02345678};
      ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ey = '{32'h00000100, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h10000000};
      eco = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      eov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tb_[i], ts[i]);
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_busy_after_accept: busy=%b done=%b, required 1/0", i, busy, done);
         end
         wait_done(1, edges, to);
         n_cmp++;
         if (to || edges != WORDS + 1) begin
            n_fail++;
            $display("FAIL dir%0d_latency: edges=%0d timeout=%b, required %0d", i, edges, to, WORDS + 1);
         end
         n_cmp++;
         if (y !== ey[i] || carry_out !== eco[i] || overflow !== eov[i] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_result: y=%h co=%b ov=%b busy=%b, required y=%h co=%b ov=%b busy=0",
                     i, y, carry_out, overflow, busy, ey[i], eco[i], eov[i]);
         end
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || y !== ey[i]) begin
            n_fail++;
            $display("FAIL dir%0d_hold: done=%b y=%h, required done=0 y=%h", i, done, y, ey[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [N-1:0] ey;
      logic         eco, eov;
      int           edges;
      logic         to;
      ref_op(32'h89ABCDEF, 32'h13579BDF, 1'b0, ey, eco, eov);
      issue(32'h89ABCDEF, 32'h13579BDF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      a     = 32'hDEADBEEF;
      b     = 32'hCAFEF00D;
      sub   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(3, edges, to);
      n_cmp++;
      if (to || edges != WORDS + 1) begin
         n_fail++;
         $display("FAIL ignore_latency: edges=%0d timeout=%b, required %0d", edges, to, WORDS + 1);
      end
      n_cmp++;
      if (y !== ey || carry_out !== eco || overflow !== eov) begin
         n_fail++;
         $display("FAIL ignore_result: y=%h co=%b ov=%b, required y=%h co=%b ov=%b",
                  y, carry_out, overflow, ey, eco, eov);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_abort();
      int seen;
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      n_cmp++;
      if ({busy, done, y, carry_out, overflow} !== '0) begin
         n_fail++;
         $display("FAIL rst_abort_state: busy=%b done=%b y=%h co=%b ov=%b, required all zero",
                  busy, done, y, carry_out, overflow);
      end
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL rst_abort_quiet: busy/done cycles=%0d, required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int   edges;
      logic to;
      issue(32'h00000000, 32'h00000001, 1'b1);
      wait_done(1, edges, to);
      n_cmp++;
      if (to || y !== 32'hFFFFFFFF || carry_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: y=%h co=%b timeout=%b, required y=ffffffff co=0", y, carry_out, to);
      end
      issue(32'h12345678, 32'h02345678, 1'b1);
      n_cmp++;
      if (y !== '0 || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: y=%h busy=%b done=%b, required y=0 busy=1 done=0", y, busy, done);
      end
      wait_done(1, edges, to);
      n_cmp++;
      if (to || edges != WORDS + 1 || y !== 32'h10000000 || carry_out !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: edges=%0d y=%h co=%b ov=%b, required edges=%0d y=10000000 co=1 ov=0",
                  edges, y, carry_out, overflow, WORDS + 1);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [N-1:0] ra, rb, ey;
      logic         rs, eco, eov;
      int           edges;
      logic         to;
      for (int i = 0; i < 60; i++) begin
         ra = $urandom();
         rb = $urandom();
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: ra = 32'h7FFFFFFF;
            2: rb = 32'h80000000;
            default: ;
         endcase
         ref_op(ra, rb, rs, ey, eco, eov);
         issue(ra, rb, rs);
         wait_done(1, edges, to);
         n_cmp++;
         if (to || edges != WORDS + 1 || y !== ey || carry_out !== eco || overflow !== eov) begin
            n_fail++;
            $display("FAIL rand%0d: a=%h b=%h sub=%b got y=%h co=%b ov=%b edges=%0d, required y=%h co=%b ov=%b edges=%0d",
                     i, ra, rb, rs, y, carry_out, overflow, edges, ey, eco, eov, WORDS + 1);
         end
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_directed();
      test_start_ignored();
      test_rst_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
